mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one N:1 mux datapath (74151 MUX8 by default, 74153/74150 widths via parameter) among N requesters.
- Drives the mux select lines and one-hot grants, and flags when mux output is valid.
- Holds each select stable for a settle cycle so TTL mux propagation never corrupts a transfer.
- Sits between requester logic and the mux data inputs; the mux output goes to the shared consumer.

Parameters:
- N, 8, number of requesters / mux inputs; legal values 4, 8, 16.
- SELW, $clog2(N), select width; derived, never overridden.
- MAXHOLD, 16, maximum cycles an owner keeps the grant before forced release; legal range 1..255.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- REQ  input  N  per-requester request; held high for the whole transfer.
- LAST  input  1  owner signals final data cycle; sampled only in OWN.
- SEL  output  SELW  mux select; S is bit 0.
- GNT  output  N  one-hot grant.
- VALID  output  1  mux output stable and owned; consumer may sample.
- BUSY  output  1  high in any state except IDLE.

Behaviour:
- Reset (RST high at a rising edge, any state): state IDLE, SEL=0, GNT=0, VALID=0, BUSY=0, pointer PTR=0, hold counter HC=0. A grant in progress is dropped immediately, with no completion cycle.
- States: IDLE, SETTLE, OWN, RELEASE.
- IDLE:
  - If REQ is nonzero, pick the first set bit searching from PTR upward, with wrap N-1 to 0.
  - Load SEL with that index, set that GNT bit, go to SETTLE.
  - GNT and SEL are visible one cycle after REQ is seen.
- SETTLE:
  - Exactly one cycle. VALID=0, SEL frozen, HC=0. Go to OWN.
- OWN:
  - VALID=1 and HC increments each cycle. VALID first rises two cycles after REQ is sampled.
  - Exit to RELEASE if any of these holds: LAST=1; REQ[SEL]=0; HC reaches MAXHOLD-1.
  - Exit precedence is LAST, then REQ drop, then timeout. All three give the same result; only an internal debug cause differs.
  - On REQ[SEL]=0, VALID drops in that same cycle (combinational gate on the owner's REQ bit), so no invalid data is marked valid.
- RELEASE:
  - One cycle. GNT=0, VALID=0, SEL holds its last value.
  - PTR = (SEL+1) mod N, so the previous owner has lowest priority next round.
  - Go to IDLE. The next grant can appear one cycle later, giving a minimum 4-cycle arbitration period per transfer.
- Timeout: a requester still asserting REQ after forced release re-competes normally. It cannot regain the grant while another requester is pending.
- SEL changes only on the IDLE→SETTLE transition. The mux select lines never toggle during SETTLE, OWN or RELEASE.
- GNT is one-hot or zero at all times. It is never two-hot, including during reset.
- REQ bits that change during SETTLE/OWN are ignored until the next IDLE evaluation.
- LAST outside OWN is ignored.
- BUSY = (state != IDLE).

Decomposition:
- Shared package `mux_arb_pkg`:
  - state enum (IDLE=2'd0, SETTLE=2'd1, OWN=2'd2, RELEASE=2'd3);
  - function clog2 for SELW;
  - localparam table of legal N values for elaboration-time assertion.
- One sub-module `rr_pick`: combinational rotating priority encoder.
  - Inputs REQ[N-1:0], PTR[SELW-1:0]; outputs IDX[SELW-1:0], HIT.
  - Implemented as double-width concatenate, shift by PTR, priority-encode, add PTR mod N.
- Select output is wired straight to the mux cell's S/T/U/V pins at the top level. No mux instance lives inside this block.

Test Plan:
- Basic, N=8: RST released, REQ=8'b0000_0100 at cycle 0.
  - Required: GNT=8'b0000_0100, SEL=2 at cycle 1; VALID=1 at cycle 2.
  - LAST at cycle 4 → GNT=0 at cycle 5, BUSY=0 at cycle 6.
- Round robin: REQ=8'hFF held constant, LAST pulsed each OWN entry.
  - Required: SEL sequence 0,1,2,…,7,0; each grant separated by exactly 4 cycles; no requester granted twice before all others.
- Wrap and skip: PTR=6 (after owner 5 released), REQ=8'b0010_0001.
  - Required: SEL=0 granted (search wraps past 6,7), not 5.
- Timeout: MAXHOLD=4, REQ[3] held, LAST never asserted, REQ[1] also high.
  - Required: VALID high exactly 4 cycles, then release.
  - Next grant is SEL=1 (wrap from PTR=4), not 3; requester 3 is re-granted afterwards.
- Early drop: owner 2 drops REQ[2] in its second OWN cycle.
  - Required: VALID=0 that same cycle, RELEASE next cycle, PTR=3.
- Reset mid-operation: assert RST during OWN with SEL=5.
  - Required: next edge GNT=0, VALID=0, SEL=0, BUSY=0, PTR=0.
  - REQ=8'b0010_0001 after reset grants SEL=0 first.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int NUM_LEGAL_N = 3;
    localparam int LEGAL_N [NUM_LEGAL_N] = '{4, 8, 16};

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit n_is_legal(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_LEGAL_N; i++) begin
            if (LEGAL_N[i] == n) begin
                ok = 1'b1;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer-side bundle of the arbiter: requests in, select/grant/status out.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int N = 8
);
    localparam int SELW = clog2(N);

    logic [N-1:0]    REQ;
    logic            LAST;
    logic [SELW-1:0] SEL;
    logic [N-1:0]    GNT;
    logic            VALID;
    logic            BUSY;

    modport master (output REQ, output LAST, input SEL, input GNT, input VALID, input BUSY);
    modport slave  (input REQ, input LAST, output SEL, output GNT, output VALID, output BUSY);
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating priority encoder: first set request at or above PTR, wrapping N-1 to 0.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    REQ,
    input  logic [SELW-1:0] PTR,
    output logic [SELW-1:0] IDX,
    output logic            HIT
);
    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic [SELW-1:0] w_enc;

    assign w_dbl = {REQ, REQ} >> PTR;
    assign w_rot = w_dbl[N-1:0];
    assign HIT   = |REQ;

    // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
    always_comb begin
        w_enc = {SELW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = SELW'(i);
            end else begin
                w_enc = w_enc;
            end
        end
    end

    // N is a power of two, so the SELW-bit sum wraps modulo N for free.
    assign IDX = w_enc + PTR;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared N:1 TTL mux: drives select/grant and holds select through a settle cycle.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N       = 8,
    parameter int MAXHOLD = 16
) (
    input  logic          CLK,
    input  logic          RST,
    mux_rr_arbiter_if.slave bus
);
    localparam int              SELW    = clog2(N);
    localparam logic [7:0]      HC_LAST = 8'(MAXHOLD - 1);
    localparam logic [SELW-1:0] SEL_ONE = {{(SELW-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]    GNT_ONE = {{(N-1){1'b0}}, 1'b1};

    if (!n_is_legal(N) || MAXHOLD < 1 || MAXHOLD > 255) begin : g_bad_param
        $fatal(1, "mux_rr_arbiter: N must be 4, 8 or 16 and MAXHOLD 1..255");
    end

    state_e          r_state;
    logic [SELW-1:0] r_sel;
    logic [N-1:0]    r_gnt;
    logic            r_valid;
    logic [SELW-1:0] r_ptr;
    logic [7:0]      r_hc;

    logic [SELW-1:0] w_idx;
    logic            w_hit;
    logic            w_own_req;
    logic            w_exit;

    rr_pick #(.N(N)) u_pick (
        .REQ (bus.REQ),
        .PTR (r_ptr),
        .IDX (w_idx),
        .HIT (w_hit)
    );

    assign w_own_req = bus.REQ[r_sel];
    assign w_exit    = bus.LAST || !w_own_req || (r_hc == HC_LAST);

    // Arbitration FSM; select is only ever loaded on leaving IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_sel   <= {SELW{1'b0}};
            r_gnt   <= {N{1'b0}};
            r_valid <= 1'b0;
            r_ptr   <= {SELW{1'b0}};
            r_hc    <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_sel   <= w_idx;
                        r_gnt   <= GNT_ONE << w_idx;
                        r_state <= SETTLE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETTLE: begin
                    r_hc    <= 8'd0;
                    r_valid <= 1'b1;
                    r_state <= OWN;
                end
                OWN: begin
                    if (w_exit) begin
                        r_gnt   <= {N{1'b0}};
                        r_valid <= 1'b0;
                        r_state <= RELEASE;
                    end else begin
                        r_hc    <= r_hc + 8'd1;
                    end
                end
                RELEASE: begin
                    r_ptr   <= r_sel + SEL_ONE;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt   <= {N{1'b0}};
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Gating with the owner's live request keeps a dropped transfer from ever showing valid.
    assign bus.VALID = r_valid & w_own_req;
    assign bus.SEL   = r_sel;
    assign bus.GNT   = r_gnt;
    assign bus.BUSY  = (r_state != IDLE);
endmodule
